// File: rtl/decode_issue_stage.sv
// Decode/issue stage feeding the execution block.
// Accepts 16-bit instructions over valid/ready and reads two operands from an
// 8-entry register file, with a same-cycle writeback bypass. It presents a
// registered issue bundle (op_dec/A/B/data_in/rd_ex/ex_valid) downstream.
// Instruction layout: [15:10] op, [9:7] rd, [6:4] rs, [3:1] rt, [3:0] imm.
// imm overlaps rt by design; data_in is the sign-extended low nibble.
module decode_issue_stage #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              ex_stall,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [OP_W-1:0]   op_dec,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] data_in,
    output logic [2:0]        rd_ex,
    output logic              ex_valid,
    output logic              illegal,
    output logic [15:0]       issue_count
);

    logic [DATA_W-1:0] regs [NREGS];

    logic [OP_W-1:0]   op;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [2:0]        rt;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              accept;

    assign op      = instr[15:10];
    assign rd      = instr[9:7];
    assign rs      = instr[6:4];
    assign rt      = instr[3:1];
    assign imm_ext = {{(DATA_W-4){instr[3]}}, instr[3:0]};

    // A stalled op that is still valid blocks the stage; an empty or draining
    // issue register can always take a new instruction.
    assign instr_ready = !ex_stall || !ex_valid;
    assign accept      = instr_valid && instr_ready;

    // Operand read: R0 is hardwired to zero, and a writeback landing on the
    // same edge wins over the stale register contents.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 3'd0) begin
            if (wb_en && (wb_addr == rs)) rs_val = wb_data;
            else                          rs_val = regs[rs];
        end
        if (rt != 3'd0) begin
            if (wb_en && (wb_addr == rt)) rt_val = wb_data;
            else                          rt_val = regs[rt];
        end
    end

    // Register file write port; writes proceed regardless of ex_stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && (wb_addr != 3'd0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Issue register: load on accept, drain when not stalled, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_dec      <= '0;
            A           <= '0;
            B           <= '0;
            data_in     <= '0;
            rd_ex       <= '0;
            ex_valid    <= 1'b0;
            illegal     <= 1'b0;
            issue_count <= '0;
        end else begin
            illegal <= 1'b0;
            if (accept) begin
                if (op[OP_W-1]) begin
                    // Illegal op is consumed but never reaches execution.
                    op_dec   <= '0;
                    ex_valid <= 1'b0;
                    illegal  <= 1'b1;
                end else begin
                    op_dec      <= op;
                    A           <= rs_val;
                    B           <= rt_val;
                    data_in     <= imm_ext;
                    rd_ex       <= rd;
                    ex_valid    <= 1'b1;
                    issue_count <= issue_count + 16'd1;
                end
            end else if (!ex_stall) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: the driver pushes the expected
// issue bundle for each instruction, and a negedge monitor pops and compares
// it in the cycle after the DUT accepts that instruction.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ex_stall;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [5:0]  op_dec;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] data_in;
    logic [2:0]  rd_ex;
    logic        ex_valid;
    logic        illegal;
    logic [15:0] issue_count;

    decode_issue_stage dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ex_stall    (ex_stall),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .op_dec      (op_dec),
        .A           (A),
        .B           (B),
        .data_in     (data_in),
        .rd_ex       (rd_ex),
        .ex_valid    (ex_valid),
        .illegal     (illegal),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ill;
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic [2:0]  rd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pend = 1'b0;
    logic mon_en = 1'b1;

    function automatic logic [15:0] mk(input logic [5:0] o, input logic [2:0] d,
                                       input logic [2:0] s, input logic [2:0] t,
                                       input logic b0);
        return {o, d, s, t, b0};
    endfunction

    function automatic logic [15:0] sx(input logic [15:0] ins);
        return {{12{ins[3]}}, ins[3:0]};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction (optionally with a concurrent writeback) and
    // hold it until the DUT accepts it, bounded by a cycle budget.
    task automatic send(input logic [15:0] ins, input logic wbe, input logic [2:0] wba,
                        input logic [15:0] wbd, input logic e_ill, input logic [15:0] ea,
                        input logic [15:0] eb, input logic [15:0] ed, input logic [15:0] ecnt);
        exp_t e;
        int   n;
        e.ill = e_ill;
        e.op  = e_ill ? 6'h00 : ins[15:10];
        e.a   = ea;
        e.b   = eb;
        e.d   = ed;
        e.rd  = ins[9:7];
        e.cnt = ecnt;
        sb.push_back(e);
        instr       = ins;
        instr_valid = 1'b1;
        wb_en       = wbe;
        wb_addr     = wba;
        wb_data     = wbd;
        n = 0;
        forever begin
            @(negedge clk);
            if (instr_ready) break;
            n++;
            if (n > 20) begin
                chk("accept_timeout", 16'(instr_ready), 16'd1);
                break;
            end
        end
        next_cycle();
        instr_valid = 1'b0;
        wb_en       = 1'b0;
    endtask

    task automatic wb(input logic [2:0] a, input logic [15:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
        next_cycle();
        wb_en = 1'b0;
    endtask

    // Monitor: compare the issue register one cycle after each accept.
    always @(negedge clk) begin
        if (pend) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: DUT accepted with no expectation at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("illegal",     16'(illegal),  16'(mon_e.ill));
                chk("ex_valid",    16'(ex_valid), 16'(!mon_e.ill));
                chk("op_dec",      16'(op_dec),   16'(mon_e.op));
                chk("issue_count", issue_count,   mon_e.cnt);
                if (!mon_e.ill) begin
                    chk("A",       A,             mon_e.a);
                    chk("B",       B,             mon_e.b);
                    chk("data_in", data_in,       mon_e.d);
                    chk("rd_ex",   16'(rd_ex),    16'(mon_e.rd));
                end
            end
        end
        pend = mon_en && !reset && instr_valid && instr_ready;
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_op_dec"},      16'(op_dec),      16'd0);
        chk({tag, "_A"},           A,                16'd0);
        chk({tag, "_B"},           B,                16'd0);
        chk({tag, "_data_in"},     data_in,          16'd0);
        chk({tag, "_rd_ex"},       16'(rd_ex),       16'd0);
        chk({tag, "_ex_valid"},    16'(ex_valid),    16'd0);
        chk({tag, "_illegal"},     16'(illegal),     16'd0);
        chk({tag, "_issue_count"}, issue_count,      16'd0);
        chk({tag, "_instr_ready"}, 16'(instr_ready), 16'd1);
    endtask

    initial begin
        reset       = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        ex_stall    = 1'b0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("rst0");
        next_cycle();

        // Basic issue: R3=0x4000, R5=0xC000; imm nibble 1010 -> 0xFFFA.
        wb(3'd3, 16'h4000);
        wb(3'd5, 16'hC000);
        send(mk(6'h01, 3'd1, 3'd3, 3'd5, 1'b0), 1'b0, 3'd0, 16'h0, 1'b0, 16'h4000, 16'hC000, 16'hFFFA, 16'd1);

        // Same-edge bypass on rs, then a plain read of the written register.
        send(mk(6'h02, 3'd2, 3'd2, 3'd3, 1'b0), 1'b1, 3'd2, 16'h1234, 1'b0, 16'h1234, 16'h4000, 16'h0006, 16'd2);
        send(mk(6'h03, 3'd3, 3'd2, 3'd2, 1'b0), 1'b0, 3'd0, 16'h0, 1'b0, 16'h1234, 16'h1234, 16'h0004, 16'd3);
        // rs == rt with a bypass hit feeds both operands.
        send(mk(6'h04, 3'd4, 3'd6, 3'd6, 1'b1), 1'b1, 3'd6, 16'hBEEF, 1'b0, 16'hBEEF, 16'hBEEF, 16'hFFFD, 16'd4);

        // Stall: freeze a valid op for 3 cycles while a writeback lands in R4.
        send(mk(6'h05, 3'd3, 3'd3, 3'd5, 1'b0), 1'b0, 3'd0, 16'h0, 1'b0, 16'h4000, 16'hC000, 16'hFFFA, 16'd5);
        begin
            exp_t e;
            e.ill = 1'b0; e.op = 6'h06; e.a = 16'h0777; e.b = 16'h1234;
            e.d = 16'h0005; e.rd = 3'd4; e.cnt = 16'd6;
            sb.push_back(e);
        end
        ex_stall    = 1'b1;
        instr       = mk(6'h06, 3'd4, 3'd4, 3'd2, 1'b1);
        instr_valid = 1'b1;
        wb_en       = 1'b1;
        wb_addr     = 3'd4;
        wb_data     = 16'h0777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready",    16'(instr_ready), 16'd0);
            chk("stall_ex_valid", 16'(ex_valid),    16'd1);
            chk("stall_op_dec",   16'(op_dec),      16'h05);
            chk("stall_A",        A,                16'h4000);
            chk("stall_count",    issue_count,      16'd5);
            next_cycle();
            wb_en = 1'b0;
        end
        ex_stall = 1'b0;
        next_cycle();
        instr_valid = 1'b0;

        // Illegal opcode is consumed, pulses illegal, does not count.
        send(mk(6'h25, 3'd1, 3'd1, 3'd1, 1'b0), 1'b0, 3'd0, 16'h0, 1'b1, 16'h0, 16'h0, 16'h0, 16'd6);
        next_cycle();
        @(negedge clk);
        chk("illegal_pulse_end", 16'(illegal), 16'd0);
        next_cycle();
        // R0 ignores writes, even with a same-edge bypass candidate.
        send(mk(6'h07, 3'd0, 3'd0, 3'd0, 1'b0), 1'b1, 3'd0, 16'hFFFF, 1'b0, 16'h0, 16'h0, 16'h0000, 16'd7);
        send(mk(6'h08, 3'd0, 3'd0, 3'd0, 1'b1), 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 16'h0, 16'h0001, 16'd8);

        // Drive issue_count to 0xFFFF with back-to-back issues, then wrap.
        mon_en      = 1'b0;
        instr       = mk(6'h01, 3'd1, 3'd1, 3'd1, 1'b0);
        instr_valid = 1'b1;
        repeat (65535 - 8) @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("count_ffff", issue_count, 16'hFFFF);
        next_cycle();
        mon_en = 1'b1;
        send(mk(6'h09, 3'd2, 3'd3, 3'd5, 1'b1), 1'b0, 3'd0, 16'h0, 1'b0, 16'h4000, 16'hC000, 16'hFFFB, 16'd0);
        send(mk(6'h0A, 3'd7, 3'd4, 3'd6, 1'b0), 1'b0, 3'd0, 16'h0, 1'b0, 16'h0777, 16'hBEEF, 16'hFFFC, 16'd1);

        // Reset while an op is valid; the concurrent writeback must be dropped.
        reset       = 1'b1;
        instr       = mk(6'h0B, 3'd1, 3'd1, 3'd1, 1'b0);
        instr_valid = 1'b1;
        wb_en       = 1'b1;
        wb_addr     = 3'd1;
        wb_data     = 16'hAAAA;
        next_cycle();
        reset       = 1'b0;
        instr_valid = 1'b0;
        wb_en       = 1'b0;
        @(negedge clk);
        chk_reset_state("rst1");
        next_cycle();
        for (int i = 1; i < 8; i++) begin
            logic [15:0] ins;
            ins = mk(6'h01, 3'(i), 3'(i), 3'(i), 1'b0);
            send(ins, 1'b0, 3'd0, 16'h0, 1'b0, 16'h0, 16'h0, sx(ins), 16'(i));
        end

        repeat (3) next_cycle();
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
